// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares one i2c_master among NUM_REQ requesters, one register transaction per grant.
// Optional macro I2C_ARB_TIMEOUT_EN adds a watchdog that aborts a stuck transaction and drains the master.
module i2c_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int NUM_ADDR_BYTES = 2,
    parameter int NUM_DATA_BYTES = 1,
    parameter int STATUS_W       = NUM_ADDR_BYTES + NUM_DATA_BYTES + 1,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int REG_ADDR_WIDTH = (NUM_ADDR_BYTES == 0) ? 1 : 8 * NUM_ADDR_BYTES,
    localparam int DW             = 8 * NUM_DATA_BYTES
) (
    input  logic                              ifclk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_reg_addr,
    input  logic [NUM_REQ*DW-1:0]             req_datai,
    output logic [NUM_REQ-1:0]                ack,
    output logic [NUM_REQ-1:0]                grant,
    output logic [DW-1:0]                     rsp_datao,
    output logic [STATUS_W-1:0]               rsp_status,
    output logic                              m_we,
    output logic                              m_re,
    output logic                              m_write_mode,
    output logic [REG_ADDR_WIDTH-1:0]         m_reg_addr,
    output logic [DW-1:0]                     m_datai,
    input  logic                              m_busy,
    input  logic                              m_done,
    input  logic [DW-1:0]                     m_datao,
    input  logic [STATUS_W-1:0]               m_status
);

    localparam int IDXW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [NUM_REQ-1:0]        grant_q, grant_d, ack_q, ack_d;
    logic [IDXW-1:0]           gidx_q, gidx_d, rr_q, rr_d, rr_next;
    logic                      m_we_q, m_we_d, m_re_q, m_re_d, wmode_q, wmode_d;
    logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DW-1:0]             wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STATUS_W-1:0]       status_q, status_d;

    logic                      found, finish, timeout, win_write;
    logic [IDXW-1:0]           sel;
    logic [REG_ADDR_WIDTH-1:0] win_addr;
    logic [DW-1:0]             win_data;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    function automatic logic [IDXW-1:0] wrap_idx(input logic [IDXW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDXW'(s);
    endfunction

    // Search starts at the round-robin pointer and wraps, so the last winner goes to the back.
    always_comb begin
        found     = 1'b0;
        sel       = '0;
        win_write = 1'b0;
        win_addr  = '0;
        win_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[wrap_idx(rr_q, k)]) begin
                found = 1'b1;
                sel   = wrap_idx(rr_q, k);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == IDXW'(i)) begin
                win_write = req_write[i];
                win_addr  = req_reg_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                win_data  = req_datai[i*DW +: DW];
            end
        end
    end

    assign rr_next = (gidx_q == IDXW'(NUM_REQ - 1)) ? '0 : gidx_q + IDXW'(1);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_d     = rr_q;
        ack_d    = '0;
        m_we_d   = 1'b0;
        m_re_d   = 1'b0;
        wmode_d  = wmode_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        finish   = 1'b0;
        timeout  = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        wd_d = 32'd0;
        if (state_q == WAIT_BUSY || state_q == WAIT_DONE) begin
            wd_d    = wd_q + 32'd1;
            timeout = !m_done && (wd_q == 32'(TIMEOUT_CYCLES - 1));
        end
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    gidx_d       = sel;
                    wmode_d      = win_write;
                    addr_d       = win_addr;
                    wdata_d      = win_data;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                m_we_d  = wmode_q;
                m_re_d  = !wmode_q;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (m_done) finish = 1'b1;
                else if (m_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (m_done) finish = 1'b1;
            end
            RESP: begin
                grant_d = '0;
                wmode_d = 1'b0;
                rr_d    = rr_next;
                state_d = IDLE;
            end
            DRAIN: begin
                if (!m_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (finish) begin
            ack_d[gidx_q] = 1'b1;
            rdata_d       = m_datao;
            status_d      = m_status;
            state_d       = RESP;
        end
        // Abort: report all-ones status now, but hold off new grants until the master goes idle.
        if (timeout) begin
            ack_d[gidx_q] = 1'b1;
            rdata_d       = '0;
            status_d      = '1;
            grant_d       = '0;
            wmode_d       = 1'b0;
            rr_d          = rr_next;
            state_d       = DRAIN;
        end
    end

    always_ff @(posedge ifclk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_q     <= '0;
            ack_q    <= '0;
            m_we_q   <= 1'b0;
            m_re_q   <= 1'b0;
            wmode_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            status_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_q     <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_q     <= rr_d;
            ack_q    <= ack_d;
            m_we_q   <= m_we_d;
            m_re_q   <= m_re_d;
            wmode_q  <= wmode_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_q     <= wd_d;
`endif
        end
    end

    assign ack          = ack_q;
    assign grant        = grant_q;
    assign rsp_datao    = rdata_q;
    assign rsp_status   = status_q;
    assign m_we         = m_we_q;
    assign m_re         = m_re_q;
    assign m_write_mode = wmode_q;
    assign m_reg_addr   = addr_q;
    assign m_datai      = wdata_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter: directed scenarios plus randomized traffic against a round-robin reference.
module tb_i2c_master_arbiter;

    localparam int NR = 4;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 50;
`else
    localparam int TB_TIMEOUT = 1000000;
`endif

    logic          ifclk = 1'b0;
    logic          reset;
    logic [3:0]    req, req_write, ack, grant;
    logic [63:0]   req_reg_addr;
    logic [31:0]   req_datai;
    logic [7:0]    rsp_datao, m_datai, m_datao;
    logic [3:0]    rsp_status, m_status;
    logic          m_we, m_re, m_write_mode, m_busy, m_done;
    logic [15:0]   m_reg_addr;

    logic [15:0]   a_arr[NR];
    logic [7:0]    d_arr[NR];
    logic          wr_arr[NR];

    assign req_reg_addr = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
    assign req_datai    = {d_arr[3], d_arr[2], d_arr[1], d_arr[0]};
    assign req_write    = {wr_arr[3], wr_arr[2], wr_arr[1], wr_arr[0]};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 ifclk = ~ifclk;

    i2c_master_arbiter #(
        .NUM_REQ(4), .NUM_ADDR_BYTES(2), .NUM_DATA_BYTES(1), .STATUS_W(4), .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .ifclk(ifclk), .reset(reset), .req(req), .req_write(req_write),
        .req_reg_addr(req_reg_addr), .req_datai(req_datai), .ack(ack), .grant(grant),
        .rsp_datao(rsp_datao), .rsp_status(rsp_status), .m_we(m_we), .m_re(m_re),
        .m_write_mode(m_write_mode), .m_reg_addr(m_reg_addr), .m_datai(m_datai),
        .m_busy(m_busy), .m_done(m_done), .m_datao(m_datao), .m_status(m_status)
    );

    // Behavioural i2c_master: reacts to a start pulse, optionally raises busy, later pulses done.
    bit         cfg_random = 0, cfg_fast = 0, cfg_hang = 0;
    int         cfg_delay  = 3;
    logic [7:0] cfg_rdata  = 8'h00;
    logic [3:0] cfg_status = 4'h0;
    bit         mst_active = 0, mst_fast = 0;
    int         mst_cnt = 0, mst_done_at = 1, n_starts = 0, n_overlap = 0;
    logic       last_start_we = 1'b0;
    logic [15:0] last_addr = '0;
    logic [7:0] last_wdata = '0, last_rdata = '0;
    logic [3:0] last_status = '0;

    initial begin
        m_busy = 1'b0; m_done = 1'b0; m_datao = '0; m_status = '0;
        forever begin
            @(negedge ifclk);
            m_done = 1'b0;
            if (reset) begin
                m_busy = 1'b0;
                mst_active = 0;
            end else if (m_we || m_re) begin
                if (mst_active || (m_we && m_re)) n_overlap++;
                n_starts++;
                last_start_we = m_we;
                last_addr     = m_reg_addr;
                last_wdata    = m_datai;
                mst_active    = 1;
                mst_cnt       = 0;
                if (cfg_random) begin
                    mst_fast    = ($urandom_range(0, 3) == 0);
                    mst_done_at = mst_fast ? 1 : int'($urandom_range(1, 6));
                    last_rdata  = 8'($urandom);
                    last_status = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                end else begin
                    mst_fast    = cfg_fast;
                    mst_done_at = cfg_delay;
                    last_rdata  = cfg_rdata;
                    last_status = cfg_status;
                end
                m_busy = !mst_fast;
            end else if (mst_active) begin
                mst_cnt++;
                if (!cfg_hang && mst_cnt >= mst_done_at) begin
                    m_done     = 1'b1;
                    m_datao    = last_rdata;
                    m_status   = last_status;
                    m_busy     = 1'b0;
                    mst_active = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge ifclk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req   = '0;
        for (int i = 0; i < NR; i++) wr_arr[i] = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic wait_ack(input int budget, output logic [3:0] a, output bit ok);
        ok = 0;
        a  = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge ifclk);
            if (ack !== 4'b0) begin
                a  = ack;
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req   = '0;
        tick(3);
        n_checks++; if (grant !== 4'b0) $display("FAIL reset_grant: got %b expected 0000", grant); else n_pass++;
        n_checks++; if (ack !== 4'b0) $display("FAIL reset_ack: got %b expected 0000", ack); else n_pass++;
        n_checks++; if ({m_we, m_re, m_write_mode} !== 3'b000) $display("FAIL reset_ctrl: got %b expected 000", {m_we, m_re, m_write_mode}); else n_pass++;
        n_checks++; if ({m_reg_addr, m_datai} !== 24'h0) $display("FAIL reset_mdata: got %h expected 0", {m_reg_addr, m_datai}); else n_pass++;
        n_checks++; if ({rsp_datao, rsp_status} !== 12'h0) $display("FAIL reset_rsp: got %h expected 0", {rsp_datao, rsp_status}); else n_pass++;
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_single_read;
        logic [3:0] a;
        bit ok;
        int s0;
        do_reset;
        cfg_random = 0; cfg_hang = 0; cfg_fast = 0; cfg_delay = 3; cfg_rdata = 8'hA5; cfg_status = 4'h0;
        a_arr[0] = 16'h0012; d_arr[0] = 8'h00; wr_arr[0] = 1'b0;
        s0 = n_starts;
        req = 4'b0001;
        tick(1);
        n_checks++; if (grant !== 4'b0001) $display("FAIL read_grant: got %b expected 0001", grant); else n_pass++;
        n_checks++; if (m_re !== 1'b0) $display("FAIL read_re_early: got %b expected 0", m_re); else n_pass++;
        tick(1);
        n_checks++; if ({m_we, m_re} !== 2'b01) $display("FAIL read_start_latency: got %b expected 01", {m_we, m_re}); else n_pass++;
        n_checks++; if (m_reg_addr !== 16'h0012) $display("FAIL read_addr: got %h expected 0012", m_reg_addr); else n_pass++;
        wait_ack(20, a, ok);
        n_checks++; if (!ok || a !== 4'b0001) $display("FAIL read_ack: got %b expected 0001", a); else n_pass++;
        n_checks++; if ({rsp_datao, rsp_status} !== {8'hA5, 4'h0}) $display("FAIL read_rsp: got %h expected a50", {rsp_datao, rsp_status}); else n_pass++;
        n_checks++; if (n_starts - s0 !== 1) $display("FAIL read_starts: got %0d expected 1", n_starts - s0); else n_pass++;
        req = '0;
        tick(1);
        n_checks++; if ({ack, grant} !== 8'h00) $display("FAIL read_after_ack: got %h expected 00", {ack, grant}); else n_pass++;
        n_checks++; if (rsp_datao !== 8'hA5) $display("FAIL read_rsp_hold: got %h expected a5", rsp_datao); else n_pass++;
    endtask

    task automatic test_round_robin;
        logic [3:0] a;
        bit ok;
        int s0;
        do_reset;
        cfg_random = 0; cfg_hang = 0; cfg_fast = 0; cfg_delay = 2; cfg_status = 4'h0;
        for (int k = 0; k < NR; k++) begin
            a_arr[k]  = 16'h1000 + 16'(k);
            d_arr[k]  = 8'h40 + 8'(k);
            wr_arr[k] = (k % 2 == 1);
        end
        s0 = n_starts;
        req = 4'b1111;
        for (int k = 0; k < NR; k++) begin
            wait_ack(30, a, ok);
            n_checks++; if (!ok || a !== (4'b0001 << k) || grant !== a) $display("FAIL rr_ack%0d: got ack %b grant %b expected %b", k, a, grant, 4'b0001 << k); else n_pass++;
            n_checks++; if ({last_start_we, last_addr} !== {wr_arr[k], a_arr[k]}) $display("FAIL rr_latch%0d: got %h expected %h", k, {last_start_we, last_addr}, {wr_arr[k], a_arr[k]}); else n_pass++;
            req = req & ~(4'b0001 << k);
        end
        tick(10);
        n_checks++; if (grant !== 4'b0) $display("FAIL rr_idle_grant: got %b expected 0000", grant); else n_pass++;
        n_checks++; if (n_starts - s0 !== 4 || n_overlap !== 0) $display("FAIL rr_starts: got %0d overlaps %0d expected 4 and 0", n_starts - s0, n_overlap); else n_pass++;
    endtask

    task automatic test_write_nack;
        logic [3:0] a;
        int bad;
        do_reset;
        cfg_random = 0; cfg_hang = 0; cfg_fast = 0; cfg_delay = 4; cfg_rdata = 8'h00; cfg_status = 4'b0010;
        a_arr[2] = 16'hBEEF; d_arr[2] = 8'h3C; wr_arr[2] = 1'b1;
        n_checks++; if (m_write_mode !== 1'b0) $display("FAIL wr_mode_idle: got %b expected 0", m_write_mode); else n_pass++;
        req = 4'b0100;
        tick(1);
        n_checks++; if ({grant, m_write_mode} !== 5'b0100_1) $display("FAIL wr_grant_mode: got %b expected 01001", {grant, m_write_mode}); else n_pass++;
        bad = 0;
        a = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge ifclk);
            if (m_write_mode !== 1'b1) bad++;
            if (ack !== 4'b0) begin
                a = ack;
                break;
            end
        end
        n_checks++; if (bad !== 0) $display("FAIL wr_mode_span: got %0d low cycles expected 0", bad); else n_pass++;
        n_checks++; if (a !== 4'b0100 || rsp_status !== 4'b0010) $display("FAIL wr_nack_ack: got %b/%b expected 0100/0010", a, rsp_status); else n_pass++;
        n_checks++; if ({last_start_we, last_addr, last_wdata} !== {1'b1, 16'hBEEF, 8'h3C}) $display("FAIL wr_master_view: got %h expected 1beef3c", {last_start_we, last_addr, last_wdata}); else n_pass++;
        req = '0;
        tick(1);
        n_checks++; if (m_write_mode !== 1'b0) $display("FAIL wr_mode_after: got %b expected 0", m_write_mode); else n_pass++;
    endtask

    task automatic test_hold_req;
        logic [3:0] a;
        bit ok;
        do_reset;
        cfg_random = 0; cfg_hang = 0; cfg_fast = 1; cfg_delay = 1; cfg_status = 4'h0;
        req = 4'b1010;
        wait_ack(30, a, ok);
        n_checks++; if (!ok || a !== 4'b0010) $display("FAIL hold_first: got %b expected 0010", a); else n_pass++;
        wait_ack(30, a, ok);
        n_checks++; if (!ok || a !== 4'b1000) $display("FAIL hold_second: got %b expected 1000", a); else n_pass++;
        req = 4'b0010;
        wait_ack(30, a, ok);
        n_checks++; if (!ok || a !== 4'b0010) $display("FAIL hold_third: got %b expected 0010", a); else n_pass++;
        req = '0;
        cfg_fast = 0;
        tick(2);
    endtask

    task automatic test_reset_mid;
        logic [3:0] a;
        bit ok;
        do_reset;
        cfg_random = 0; cfg_hang = 1; cfg_fast = 0; cfg_delay = 2; cfg_rdata = 8'h77; cfg_status = 4'h0;
        a_arr[0] = 16'h5555; d_arr[0] = 8'h66; wr_arr[0] = 1'b1;
        req = 4'b0001;
        for (int c = 0; c < 20 && m_busy !== 1'b1; c++) tick(1);
        tick(2);
        n_checks++; if ({grant, m_write_mode} !== 5'b0001_1) $display("FAIL mid_pre: got %b expected 00011", {grant, m_write_mode}); else n_pass++;
        reset = 1'b1;
        req   = '0;
        tick(1);
        n_checks++; if ({grant, ack} !== 8'h00) $display("FAIL mid_grant_ack: got %h expected 00", {grant, ack}); else n_pass++;
        n_checks++; if ({m_we, m_re, m_write_mode, m_reg_addr, m_datai} !== 27'h0) $display("FAIL mid_mout: got %h expected 0", {m_we, m_re, m_write_mode, m_reg_addr, m_datai}); else n_pass++;
        reset = 1'b0;
        cfg_hang = 0;
        wr_arr[0] = 1'b0;
        a_arr[3] = 16'h0303; wr_arr[3] = 1'b0;
        req = 4'b1000;
        wait_ack(30, a, ok);
        n_checks++; if (!ok || a !== 4'b1000) $display("FAIL mid_recover: got %b expected 1000", a); else n_pass++;
        req = '0;
        tick(2);
    endtask

    task automatic test_random;
        localparam int TOTAL = 40;
        int rr_m, g_exp, pick, issued, served, s_grant, acked, idx;
        do_reset;
        cfg_random = 1; cfg_hang = 0;
        rr_m = 0; g_exp = -1; issued = 0; served = 0; s_grant = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge ifclk);
            acked = -1;
            if (grant !== 4'b0 && g_exp < 0) begin
                pick = -1;
                for (int k = 0; k < NR; k++) begin
                    idx = (rr_m + k) % NR;
                    if (pick < 0 && ((req >> idx) & 4'b0001) != 4'b0) pick = idx;
                end
                n_checks++; if (pick < 0 || grant !== (4'b0001 << pick)) $display("FAIL rand_grant: got %b expected index %0d", grant, pick); else n_pass++;
                if (pick < 0) pick = 0;
                n_checks++; if ({m_write_mode, m_reg_addr, m_datai} !== {wr_arr[pick], a_arr[pick], d_arr[pick]}) $display("FAIL rand_latch: got %h expected %h", {m_write_mode, m_reg_addr, m_datai}, {wr_arr[pick], a_arr[pick], d_arr[pick]}); else n_pass++;
                g_exp   = pick;
                s_grant = n_starts;
            end
            if (ack !== 4'b0) begin
                n_checks++; if (g_exp < 0 || ack !== (4'b0001 << g_exp)) $display("FAIL rand_ack: got %b expected index %0d", ack, g_exp); else n_pass++;
                if (g_exp >= 0) begin
                    n_checks++; if ({rsp_datao, rsp_status} !== {last_rdata, last_status}) $display("FAIL rand_rsp: got %h expected %h", {rsp_datao, rsp_status}, {last_rdata, last_status}); else n_pass++;
                    n_checks++; if (n_starts - s_grant !== 1 || last_start_we !== wr_arr[g_exp]) $display("FAIL rand_start: got %0d starts we=%b expected 1 we=%b", n_starts - s_grant, last_start_we, wr_arr[g_exp]); else n_pass++;
                    served++;
                    rr_m  = (g_exp + 1) % NR;
                    req   = req & ~(4'b0001 << g_exp);
                    acked = g_exp;
                end
                g_exp = -1;
            end
            if (served >= TOTAL && issued >= TOTAL) break;
            for (int i = 0; i < NR; i++) begin
                if (i != acked && ((req >> i) & 4'b0001) == 4'b0 && issued < TOTAL && $urandom_range(0, 5) == 0) begin
                    a_arr[i]  = 16'($urandom);
                    d_arr[i]  = 8'($urandom);
                    wr_arr[i] = 1'($urandom_range(0, 1));
                    req       = req | (4'b0001 << i);
                    issued++;
                end
            end
        end
        n_checks++; if (served !== TOTAL) $display("FAIL rand_complete: got %0d served expected %0d", served, TOTAL); else n_pass++;
        n_checks++; if (n_overlap !== 0) $display("FAIL rand_overlap: got %0d expected 0", n_overlap); else n_pass++;
        cfg_random = 0;
        req = '0;
        tick(2);
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout;
        logic [3:0] a;
        bit ok;
        int cnt, nz;
        do_reset;
        cfg_random = 0; cfg_hang = 1; cfg_fast = 0; cfg_delay = 2; cfg_rdata = 8'h99; cfg_status = 4'h0;
        a_arr[2] = 16'h2222; wr_arr[2] = 1'b0;
        req = 4'b0100;
        for (int c = 0; c < 10 && m_re !== 1'b1; c++) tick(1);
        cnt = 0;
        a = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge ifclk);
            cnt++;
            if (ack !== 4'b0) begin
                a = ack;
                break;
            end
        end
        n_checks++; if (a !== 4'b0100 || cnt !== TB_TIMEOUT) $display("FAIL to_ack: got %b after %0d expected 0100 after %0d", a, cnt, TB_TIMEOUT); else n_pass++;
        n_checks++; if ({rsp_datao, rsp_status} !== 12'h00F) $display("FAIL to_rsp: got %h expected 00f", {rsp_datao, rsp_status}); else n_pass++;
        req = 4'b0001;
        nz = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge ifclk);
            if (grant !== 4'b0) nz++;
        end
        n_checks++; if (nz !== 0) $display("FAIL to_drain_grant: got %0d grant cycles expected 0", nz); else n_pass++;
        cfg_hang = 0;
        for (int c = 0; c < 10 && grant === 4'b0; c++) tick(1);
        n_checks++; if (grant !== 4'b0001) $display("FAIL to_regrant: got %b expected 0001", grant); else n_pass++;
        wait_ack(30, a, ok);
        n_checks++; if (!ok || a !== 4'b0001 || rsp_status !== 4'h0) $display("FAIL to_after: got %b/%h expected 0001/0", a, rsp_status); else n_pass++;
        req = '0;
        tick(2);
    endtask
`endif

    initial begin
        reset = 1'b1;
        req   = '0;
        for (int i = 0; i < NR; i++) begin
            a_arr[i]  = '0;
            d_arr[i]  = '0;
            wr_arr[i] = 1'b0;
        end
        test_reset;
        test_single_read;
        test_round_robin;
        test_write_nack;
        test_hold_req;
        test_reset_mid;
        test_random;
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout;
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
